// File: rtl/instruction_fetch.sv
// Fetch stage: reads instruction words at the PC, resolves local BR branches, accepts execute redirects,
// and presents fetched words to decode through a valid/ready handshake.
module instruction_fetch #(
    parameter logic [6:0]  BR_OPCODE = 7'b1100000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] PcValue,
    output logic        PcLoadEnable,
    output logic [15:0] PcLoadValue,
    output logic        PcOffsetEnable,
    output logic [8:0]  PcOffset,
    output logic [15:0] MemAddr,
    output logic        MemReq,
    input  logic        MemAck,
    input  logic [15:0] MemData,
    output logic [15:0] Instr,
    output logic [15:0] InstrPc,
    output logic        InstrValid,
    input  logic        DecodeReady,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic        FetchError
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic [WORD_W-1:0]   instr_nxt, instr_pc_nxt;
    logic                instr_valid_nxt, fetch_error_nxt;

    assign MemAddr = PcValue;

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            Instr      <= '0;
            InstrPc    <= '0;
            InstrValid <= 1'b0;
            FetchError <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            Instr      <= instr_nxt;
            InstrPc    <= instr_pc_nxt;
            InstrValid <= instr_valid_nxt;
            FetchError <= fetch_error_nxt;
        end
    end

    // Next-state, PC control and memory request
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        instr_nxt       = Instr;
        instr_pc_nxt    = InstrPc;
        instr_valid_nxt = InstrValid;
        fetch_error_nxt = FetchError;
        PcLoadEnable    = 1'b0;
        PcLoadValue     = '0;
        PcOffsetEnable  = 1'b0;
        PcOffset        = '0;
        MemReq          = 1'b0;

        case (state)
            S_IDLE: begin
                PcOffsetEnable = 1'b1;
                wait_cnt_nxt   = '0;
                state_nxt      = S_REQ;
            end
            S_REQ: begin
                MemReq = 1'b1;
                if (MemAck) begin
                    if (MemData == HALT_WORD) begin
                        PcOffsetEnable = 1'b1;
                        state_nxt      = S_HALTED;
                    end else if (MemData[15:9] == BR_OPCODE) begin
                        // Local branch: PC applies the signed offset, fetch restarts at the target
                        PcOffsetEnable = 1'b1;
                        PcOffset       = MemData[8:0];
                        wait_cnt_nxt   = '0;
                    end else begin
                        instr_nxt       = MemData;
                        instr_pc_nxt    = PcValue;
                        instr_valid_nxt = 1'b1;
                        state_nxt       = S_HOLD;
                    end
                end else begin
                    PcOffsetEnable = 1'b1;
                    if (wait_cnt >= CNT_W'(MAX_WAIT - 1)) begin
                        fetch_error_nxt = 1'b1;
                        state_nxt       = S_HALTED;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                PcOffsetEnable = 1'b1;
                if (DecodeReady) begin
                    instr_valid_nxt = 1'b0;
                    wait_cnt_nxt    = '0;
                    state_nxt       = S_REQ;
                end
            end
            S_HALTED: begin
                PcOffsetEnable  = 1'b1;
                instr_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Execute redirect wins over everything except reset and the IDLE start-up cycle
        if (BranchTaken && (state != S_IDLE)) begin
            PcLoadEnable    = 1'b1;
            PcLoadValue     = BranchTarget;
            PcOffsetEnable  = 1'b0;
            PcOffset        = '0;
            instr_nxt       = Instr;
            instr_pc_nxt    = InstrPc;
            instr_valid_nxt = 1'b0;
            fetch_error_nxt = FetchError;
            wait_cnt_nxt    = '0;
            state_nxt       = S_REQ;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: models the PC and a combinational-ack instruction memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_load_en, pc_off_en, mem_req, mem_ack, instr_valid, fetch_error;
    logic [15:0] pc_load_value, mem_addr, mem_data, instr, instr_pc, br_target;
    logic [8:0]  pc_off;
    logic        ready, br_taken, ack_en;
    logic [15:0] pc_init;
    logic [15:0] mem [0:65535];

    int n_vec = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .Clock(clk), .Reset(reset), .PcValue(pc),
        .PcLoadEnable(pc_load_en), .PcLoadValue(pc_load_value),
        .PcOffsetEnable(pc_off_en), .PcOffset(pc_off),
        .MemAddr(mem_addr), .MemReq(mem_req), .MemAck(mem_ack), .MemData(mem_data),
        .Instr(instr), .InstrPc(instr_pc), .InstrValid(instr_valid),
        .DecodeReady(ready), .BranchTaken(br_taken), .BranchTarget(br_target),
        .FetchError(fetch_error)
    );

    // Memory answers in the same cycle as the request when enabled
    assign mem_ack  = mem_req & ack_en;
    assign mem_data = mem[mem_addr];

    // Program counter: load beats offset, otherwise increment
    always @(posedge clk) begin
        if (reset)           pc <= pc_init;
        else if (pc_load_en) pc <= pc_load_value;
        else if (pc_off_en)  pc <= pc + {{7{pc_off[8]}}, pc_off};
        else                 pc <= pc + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] start);
        reset    = 1'b1;
        pc_init  = start;
        br_taken = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h5678;
        mem[16'h0002] = 16'h2222;
        mem[16'h0003] = 16'hFFFF;
        mem[16'h0010] = {7'b1100000, 9'h1F0};
        mem[16'h0200] = 16'hABCD;
        mem[16'h0300] = 16'h1111;
        mem[16'hFFFF] = 16'h3333;
        ready = 1'b1; ack_en = 1'b1; br_target = 16'h0000; br_taken = 1'b0;

        // Reset values and two back-to-back fetches
        do_reset(16'h0000);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_ipc", 32'(instr_pc), 32'h0);
        check("rst_err", 32'(fetch_error), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
        check("idle_hold", 32'({pc_off_en, pc_off}), 32'h200);
        step();
        check("req0_req", 32'(mem_req), 32'd1);
        check("req0_addr", 32'(mem_addr), 32'h0000);
        check("req0_nostrobe", 32'({pc_load_en, pc_off_en}), 32'd0);
        step();
        check("f0_valid", 32'(instr_valid), 32'd1);
        check("f0_instr", 32'(instr), 32'h1234);
        check("f0_ipc", 32'(instr_pc), 32'h0000);
        check("f0_req", 32'(mem_req), 32'd0);
        step();
        check("req1_addr", 32'(mem_addr), 32'h0001);
        step();
        check("f1_instr", 32'(instr), 32'h5678);
        check("f1_ipc", 32'(instr_pc), 32'h0001);

        // Local BR of -16 from 0x0010
        do_reset(16'h0010);
        step();
        check("br_offen", 32'(pc_off_en), 32'd1);
        check("br_off", 32'(pc_off), 32'h1F0);
        check("br_noload", 32'(pc_load_en), 32'd0);
        ready = 1'b0;
        step();
        check("br_next_addr", 32'(mem_addr), 32'h0000);
        check("br_novalid", 32'(instr_valid), 32'd0);
        check("br_req", 32'(mem_req), 32'd1);
        step();

        // Decode back-pressure for five cycles
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", 32'(instr), 32'h1234);
            check("bp_ipc", 32'(instr_pc), 32'h0000);
            check("bp_hold", 32'({pc_off_en, pc_off}), 32'h200);
            check("bp_req", 32'(mem_req), 32'd0);
            if (i < 4) step();
        end
        ready = 1'b1;
        step();
        check("bp_release", 32'(instr_valid), 32'd0);
        check("bp_next_addr", 32'(mem_addr), 32'h0001);

        // Redirect in the same cycle as an ack
        br_taken = 1'b1; br_target = 16'h0200;
        #1;
        check("rd_load", 32'({pc_load_en, pc_off_en}), 32'h2);
        check("rd_value", 32'(pc_load_value), 32'h0200);
        step();
        br_taken = 1'b0;
        check("rd_discard", 32'(instr_valid), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'h0200);
        step();
        check("rd_instr", 32'(instr), 32'hABCD);
        check("rd_ipc", 32'(instr_pc), 32'h0200);

        // Memory timeout, recovery by redirect, sticky error
        ack_en = 1'b0;
        do_reset(16'h0040);
        step();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("to_cycles", 32'(n), 32'd15);
        check("to_err", 32'(fetch_error), 32'd1);
        check("to_pc_held", 32'(mem_addr), 32'h0040);
        check("to_halt_hold", 32'({pc_off_en, pc_off}), 32'h200);
        ack_en = 1'b1; br_taken = 1'b1; br_target = 16'h0300;
        #1;
        check("to_br_load", 32'({pc_load_en, pc_off_en}), 32'h2);
        step();
        br_taken = 1'b0;
        check("to_rec_addr", 32'(mem_addr), 32'h0300);
        check("to_rec_req", 32'(mem_req), 32'd1);
        step();
        check("to_rec_instr", 32'(instr), 32'h1111);
        check("to_err_sticky", 32'(fetch_error), 32'd1);
        do_reset(16'h0000);
        check("to_err_clr", 32'(fetch_error), 32'd0);

        // Halt word at 0x0003
        n = 0;
        while (!(mem_req && mem_addr == 16'h0003) && n < 20) begin
            n++;
            step();
        end
        check("halt_reach", 32'({mem_req, mem_addr}), 32'h10003);
        check("halt_hold", 32'({pc_load_en, pc_off_en, pc_off}), 32'h200);
        step();
        for (int i = 0; i < 20; i++) begin
            check("halt_pc", 32'(mem_addr), 32'h0003);
            check("halt_req", 32'(mem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            step();
        end
        check("halt_last_ipc", 32'(instr_pc), 32'h0002);

        // Reset while an ack is present
        br_taken = 1'b1; br_target = 16'h0000;
        step();
        br_taken = 1'b0;
        check("mr_req", 32'({mem_req, mem_ack}), 32'h3);
        reset = 1'b1; pc_init = 16'h0000;
        step();
        reset = 1'b0;
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_instr", 32'(instr), 32'h0);
        check("mr_ipc", 32'(instr_pc), 32'h0);
        check("mr_req_off", 32'(mem_req), 32'd0);

        // PC wrap at 0xFFFF, redirect ignored in IDLE
        do_reset(16'hFFFF);
        br_taken = 1'b1; br_target = 16'h0500;
        #1;
        check("idle_br_ign", 32'({pc_load_en, pc_off_en}), 32'h1);
        step();
        br_taken = 1'b0;
        check("wrap_addr", 32'(mem_addr), 32'hFFFF);
        step();
        check("wrap_instr", 32'(instr), 32'h3333);
        check("wrap_ipc", 32'(instr_pc), 32'hFFFF);
        step();
        check("wrap_next", 32'(mem_addr), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
